bru_redirect_ctrl: RTL and testbench

//  Collects resolved-branch results from all misc/branch FUs and selects the oldest mispredict by ROB age.

---
 rtl/bru_redirect_ctrl_pkg.sv | 32 +++
 rtl/bru_redirect_ctrl_rob_age_select.sv | 41 ++++
 rtl/bru_redirect_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bru_redirect_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_redirect_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bru_redirect_ctrl_pkg                                              |
// | Shared branch-result types, ROB geometry and ROB age comparison.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bru_redirect_ctrl_pkg;

  localparam int c_ROB_SIZE  = 64;
  localparam int c_XLEN      = 64;
  localparam int c_IDX_W     = $clog2(c_ROB_SIZE);
  localparam int c_ROBIDX_W  = c_IDX_W + 1;

  // robIdx = {wrap flag, entry index}
  typedef logic [c_ROBIDX_W-1:0] robIdx_t;

  typedef struct packed {
    logic              vld;
    logic              misPred;
    robIdx_t           robIdx;
    logic [c_XLEN-1:0] targetpc;
  } bruResult_t;

  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    if (a[c_ROBIDX_W-1] == b[c_ROBIDX_W-1]) begin
      return a[c_IDX_W-1:0] < b[c_IDX_W-1:0];
    end
    return a[c_IDX_W-1:0] > b[c_IDX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bru_redirect_ctrl_rob_age_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rob_age_select                                                     |
// | Combinational pick of the oldest valid mispredicting lane.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rob_age_select
  import bru_redirect_ctrl_pkg::*;
#(
  parameter int NUM_BRU = 2,
  parameter int LANE_W  = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1
) (
  input  logic [NUM_BRU-1:0]             i_vld,
  input  logic [NUM_BRU-1:0]             i_misPred,
  input  robIdx_t [NUM_BRU-1:0]          i_robIdx,
  input  logic [NUM_BRU-1:0][c_XLEN-1:0] i_pc,
  output logic                           o_valid,
  output logic [LANE_W-1:0]              o_lane,
  output robIdx_t                        o_robIdx,
  output logic [c_XLEN-1:0]              o_pc
);

  // Strictly-older replacement keeps the lowest lane on equal robIdx.
  always_comb begin
    o_valid  = 1'b0;
    o_lane   = '0;
    o_robIdx = '0;
    o_pc     = '0;
    for (int i = 0; i < NUM_BRU; i++) begin
      if (i_vld[i] && i_misPred[i] &&
          (!o_valid || rob_older(i_robIdx[i], o_robIdx))) begin
        o_valid  = 1'b1;
        o_lane   = LANE_W'(i);
        o_robIdx = i_robIdx[i];
        o_pc     = i_pc[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bru_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bru_redirect_ctrl                                                  |
// | Oldest-mispredict redirect holder with fixed recovery window.      |
// | Optional BRU_REDIRECT_PERF_EN adds mispredict/redirect counters.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bru_redirect_ctrl
  import bru_redirect_ctrl_pkg::*;
#(
  parameter int NUM_BRU        = 2,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BRU-1:0]            i_bru_vld,
  input  logic [NUM_BRU-1:0]            i_bru_misPred,
  input  logic [NUM_BRU*c_ROBIDX_W-1:0] i_bru_robIdx,
  input  logic [NUM_BRU*c_XLEN-1:0]     i_bru_targetpc,
  input  logic                          i_flush,
  input  logic                          i_redirect_rdy,
  output logic                          o_redirect_vld,
  output logic [c_XLEN-1:0]             o_redirect_pc,
  output logic [c_ROBIDX_W-1:0]         o_redirect_robIdx,
  output logic                          o_squash,
  output logic                          o_issue_block
`ifdef BRU_REDIRECT_PERF_EN
  ,
  output logic [31:0]                   o_perf_mispred_cnt,
  output logic [31:0]                   o_perf_redirect_cnt
`endif
);

  localparam int c_CNT_W  = $clog2(RECOVER_CYCLES + 1);
  localparam int c_LANE_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RECOVER = 2'd2
  } redirState_t;

  redirState_t                  r_state, w_nxt_state;
  logic                         r_held_vld, w_nxt_held_vld;
  robIdx_t                      r_held_rob, w_nxt_held_rob;
  logic [c_XLEN-1:0]            r_held_pc, w_nxt_held_pc;
  robIdx_t                      r_sq_rob, w_nxt_sq_rob;
  logic [c_CNT_W-1:0]           r_cnt, w_nxt_cnt;

  robIdx_t [NUM_BRU-1:0]        w_lane_rob;
  logic [NUM_BRU-1:0][c_XLEN-1:0] w_lane_pc;
  logic                         w_cand_vld;
  logic [c_LANE_W-1:0]          w_cand_lane_unused;
  robIdx_t                      w_cand_rob;
  logic [c_XLEN-1:0]            w_cand_pc;

  assign w_lane_rob = i_bru_robIdx;
  assign w_lane_pc  = i_bru_targetpc;

  rob_age_select #(
    .NUM_BRU (NUM_BRU),
    .LANE_W  (c_LANE_W)
  ) u_sel (
    .i_vld     (i_bru_vld),
    .i_misPred (i_bru_misPred),
    .i_robIdx  (w_lane_rob),
    .i_pc      (w_lane_pc),
    .o_valid   (w_cand_vld),
    .o_lane    (w_cand_lane_unused),
    .o_robIdx  (w_cand_rob),
    .o_pc      (w_cand_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_held_vld <= 1'b0;
      r_held_rob <= '0;
      r_held_pc  <= '0;
      r_sq_rob   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_held_vld <= w_nxt_held_vld;
      r_held_rob <= w_nxt_held_rob;
      r_held_pc  <= w_nxt_held_pc;
      r_sq_rob   <= w_nxt_sq_rob;
      r_cnt      <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_held_vld = r_held_vld;
    w_nxt_held_rob = r_held_rob;
    w_nxt_held_pc  = r_held_pc;
    w_nxt_sq_rob   = r_sq_rob;
    w_nxt_cnt      = r_cnt;
    o_squash       = 1'b0;
    if (i_flush) begin
      w_nxt_state    = IDLE;
      w_nxt_held_vld = 1'b0;
      w_nxt_held_rob = '0;
      w_nxt_held_pc  = '0;
      w_nxt_cnt      = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cand_vld) begin
            w_nxt_state    = PENDING;
            w_nxt_held_vld = 1'b1;
            w_nxt_held_rob = w_cand_rob;
            w_nxt_held_pc  = w_cand_pc;
          end
        end
        PENDING: begin
          if (i_redirect_rdy) begin
            o_squash       = 1'b1;
            w_nxt_state    = RECOVER;
            w_nxt_sq_rob   = r_held_rob;
            w_nxt_cnt      = c_CNT_W'(RECOVER_CYCLES);
            w_nxt_held_vld = 1'b0;
            // The held slot is free from here on; reuse it for an older miss.
            if (w_cand_vld && rob_older(w_cand_rob, r_held_rob)) begin
              w_nxt_held_vld = 1'b1;
              w_nxt_held_rob = w_cand_rob;
              w_nxt_held_pc  = w_cand_pc;
            end
          end else if (w_cand_vld && rob_older(w_cand_rob, r_held_rob)) begin
            w_nxt_held_rob = w_cand_rob;
            w_nxt_held_pc  = w_cand_pc;
          end
        end
        RECOVER: begin
          w_nxt_cnt = r_cnt - c_CNT_W'(1);
          if (w_cand_vld && rob_older(w_cand_rob, r_sq_rob) &&
              (!r_held_vld || rob_older(w_cand_rob, r_held_rob))) begin
            w_nxt_held_vld = 1'b1;
            w_nxt_held_rob = w_cand_rob;
            w_nxt_held_pc  = w_cand_pc;
          end
          if (r_cnt == c_CNT_W'(1)) begin
            w_nxt_state = w_nxt_held_vld ? PENDING : IDLE;
          end
        end
        default: begin
          w_nxt_state    = IDLE;
          w_nxt_held_vld = 1'b0;
        end
      endcase
    end
  end

  assign o_redirect_vld    = (r_state == PENDING);
  assign o_issue_block     = (r_state != IDLE);
  assign o_redirect_pc     = r_held_pc;
  assign o_redirect_robIdx = r_held_rob;

`ifdef BRU_REDIRECT_PERF_EN
  logic [31:0] r_perf_mispred_cnt;
  logic [31:0] r_perf_redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_mispred_cnt  <= '0;
      r_perf_redirect_cnt <= '0;
    end else begin
      if (w_cand_vld) r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
      if (o_squash)   r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
    end
  end

  assign o_perf_mispred_cnt  = r_perf_mispred_cnt;
  assign o_perf_redirect_cnt = r_perf_redirect_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bru_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bru_redirect_ctrl                                               |
// | Directed vector table, async-reset sequence and randomized run.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bru_redirect_ctrl;

  localparam int c_RC = 3;

  logic         clk;
  logic         rst;
  logic [1:0]   i_bru_vld;
  logic [1:0]   i_bru_misPred;
  logic [13:0]  i_bru_robIdx;
  logic [127:0] i_bru_targetpc;
  logic         i_flush;
  logic         i_redirect_rdy;
  logic         o_redirect_vld;
  logic [63:0]  o_redirect_pc;
  logic [6:0]   o_redirect_robIdx;
  logic         o_squash;
  logic         o_issue_block;
`ifdef BRU_REDIRECT_PERF_EN
  logic [31:0]  o_perf_mispred_cnt;
  logic [31:0]  o_perf_redirect_cnt;
`endif

  bru_redirect_ctrl #(.NUM_BRU(2), .RECOVER_CYCLES(c_RC)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_bru_vld         (i_bru_vld),
    .i_bru_misPred     (i_bru_misPred),
    .i_bru_robIdx      (i_bru_robIdx),
    .i_bru_targetpc    (i_bru_targetpc),
    .i_flush           (i_flush),
    .i_redirect_rdy    (i_redirect_rdy),
    .o_redirect_vld    (o_redirect_vld),
    .o_redirect_pc     (o_redirect_pc),
    .o_redirect_robIdx (o_redirect_robIdx),
    .o_squash          (o_squash),
    .o_issue_block     (o_issue_block)
`ifdef BRU_REDIRECT_PERF_EN
    ,
    .o_perf_mispred_cnt  (o_perf_mispred_cnt),
    .o_perf_redirect_cnt (o_perf_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  mp;
    logic [6:0]  r0;
    logic [6:0]  r1;
    logic [63:0] p0;
    logic [63:0] p1;
    logic        fl;
    logic        rd;
    logic        ev;
    logic [6:0]  erob;
    logic [63:0] epc;
    logic        esq;
    logic        eblk;
  } vec_t;

  vec_t tbl[$];
  int   checks;
  int   failures;

  // Reference model state, kept in spec terms
  bit          m_pend;
  bit          m_have;
  int          m_win;
  logic [6:0]  m_rob;
  logic [63:0] m_pc;
  logic [6:0]  m_sq;
  int          m_mis;
  int          m_hs;

  // a is older than b when b sits 1..63 entries after a on the 128-step ring
  function automatic bit older(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = b - a;
    return (d >= 7'd1) && (d <= 7'd63);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] vld, input logic [1:0] mp,
                     input logic [6:0] r0, input logic [6:0] r1,
                     input logic [63:0] p0, input logic [63:0] p1,
                     input logic fl, input logic rd,
                     input logic ev, input logic [6:0] erob, input logic [63:0] epc,
                     input logic esq, input logic eblk);
    vec_t v;
    v.vld = vld; v.mp = mp; v.r0 = r0; v.r1 = r1; v.p0 = p0; v.p1 = p1;
    v.fl = fl; v.rd = rd; v.ev = ev; v.erob = erob; v.epc = epc;
    v.esq = esq; v.eblk = eblk;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic [1:0] vld, input logic [1:0] mp,
                       input logic [6:0] r0, input logic [6:0] r1,
                       input logic [63:0] p0, input logic [63:0] p1,
                       input logic fl, input logic rd);
    @(negedge clk);
    i_bru_vld      = vld;
    i_bru_misPred  = mp;
    i_bru_robIdx   = {r1, r0};
    i_bru_targetpc = {p1, p0};
    i_flush        = fl;
    i_redirect_rdy = rd;
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_have = 0; m_win = 0; m_rob = '0; m_pc = '0; m_sq = '0;
    m_mis = 0; m_hs = 0;
  endtask

  // Advance the model across one rising edge using the inputs now driven
  task automatic model_edge();
    bit          cf;
    logic [6:0]  cr;
    logic [63:0] cp;
    logic [6:0]  r;
    cf = 0; cr = '0; cp = '0;
    for (int l = 0; l < 2; l++) begin
      r = i_bru_robIdx[l*7 +: 7];
      if (i_bru_vld[l] && i_bru_misPred[l] && (!cf || older(r, cr))) begin
        cf = 1; cr = r; cp = i_bru_targetpc[l*64 +: 64];
      end
    end
    if (cf) m_mis++;
    if (i_flush) begin
      m_pend = 0; m_have = 0; m_win = 0;
    end else if (m_pend) begin
      if (i_redirect_rdy) begin
        m_hs++;
        m_sq = m_rob; m_win = c_RC; m_pend = 0; m_have = 0;
        if (cf && older(cr, m_sq)) begin m_have = 1; m_rob = cr; m_pc = cp; end
      end else if (cf && older(cr, m_rob)) begin
        m_rob = cr; m_pc = cp;
      end
    end else if (m_win > 0) begin
      if (cf && older(cr, m_sq) && (!m_have || older(cr, m_rob))) begin
        m_have = 1; m_rob = cr; m_pc = cp;
      end
      m_win--;
      if (m_win == 0) m_pend = m_have;
    end else if (cf) begin
      m_pend = 1; m_have = 1; m_rob = cr; m_pc = cp;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " vld"}, 64'(o_redirect_vld), 64'(m_pend));
    chk({tag, " blk"}, 64'(o_issue_block), 64'(m_pend || (m_win > 0)));
    chk({tag, " squash"}, 64'(o_squash), 64'(m_pend && i_redirect_rdy && !i_flush));
    if (m_pend) begin
      chk({tag, " rob"}, 64'(o_redirect_robIdx), 64'(m_rob));
      chk({tag, " pc"}, o_redirect_pc, m_pc);
    end
  endtask

`ifdef BRU_REDIRECT_PERF_EN
  task automatic check_perf(input string tag);
    chk({tag, " perf_mis"}, 64'(o_perf_mispred_cnt), 64'(m_mis));
    chk({tag, " perf_redir"}, 64'(o_perf_redirect_cnt), 64'(m_hs));
  endtask
`endif

  initial begin
    logic [63:0] p1a, p2a, p2b, p3a, p3b, p3c, p4a, p4b, p5a, p5b, p5c, p6;
    string nm;
    checks = 0; failures = 0;
    p1a = 64'h8000_1000; p2a = 64'h8000_2000; p2b = 64'h8000_3000;
    p3a = 64'h8000_4000; p3b = 64'h8000_5000; p3c = 64'h8000_6000;
    p4a = 64'h8000_7000; p4b = 64'h8000_8000; p5a = 64'h8000_9000;
    p5b = 64'h8000_A000; p5c = 64'h8000_B000; p6  = 64'h8000_C000;

    // Rows: inputs | expected outputs seen before that row's clock edge
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,0); // idle
    add(2'b01,2'b01,  5, 0, p1a,   0,0,0, 0, 0,   0,0,0); // miss {0,5}
    add(2'b00,2'b00,  0, 0,   0,   0,0,1, 1, 5, p1a,1,1); // handshake
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,0); // back to idle
    add(2'b11,2'b11,  9, 3, p2a, p2b,0,0, 0, 0,   0,0,0); // two lanes
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 1, 3, p2b,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,1, 1, 3, p2b,1,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b01,2'b01, 10, 0, p3a,   0,0,0, 0, 0,   0,0,0); // {0,10}
    add(2'b10,2'b10,  0, 4,   0, p3b,0,0, 1,10, p3a,0,1); // older {0,4}
    add(2'b01,2'b01, 12, 0, p3c,   0,0,0, 1, 4, p3b,0,1); // younger {0,12}
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 1, 4, p3b,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,1, 1, 4, p3b,1,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b01,2'b01, 66, 0, p4a,   0,0,0, 0, 0,   0,0,0); // {1,2}
    add(2'b10,2'b10,  0,62,   0, p4b,0,0, 1,66, p4a,0,1); // {0,62} older
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 1,62, p4b,0,1);
    add(2'b01,2'b01, 20, 0, p5a,   0,0,1, 1,62, p4b,1,1); // miss in handshake
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,1, 1,20, p5a,1,1); // squash {0,20}
    add(2'b01,2'b01,  8, 0, p5b,   0,0,0, 0, 0,   0,0,1); // older, kept
    add(2'b10,2'b10,  0,25,   0, p5c,0,0, 0, 0,   0,0,1); // younger, dropped
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,1);
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 1, 8, p5b,0,1);
    add(2'b01,2'b01,  1, 0,  p6,   0,1,0, 1, 8, p5b,0,1); // flush
    add(2'b00,2'b00,  0, 0,   0,   0,0,0, 0, 0,   0,0,0);

    rst = 1'b1;
    i_bru_vld = '0; i_bru_misPred = '0; i_bru_robIdx = '0; i_bru_targetpc = '0;
    i_flush = 1'b0; i_redirect_rdy = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset vld", 64'(o_redirect_vld), 64'd0);
    chk("reset blk", 64'(o_issue_block), 64'd0);
    chk("reset squash", 64'(o_squash), 64'd0);
    chk("reset pc", o_redirect_pc, 64'd0);
    chk("reset rob", 64'(o_redirect_robIdx), 64'd0);
`ifdef BRU_REDIRECT_PERF_EN
    check_perf("reset");
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].vld, tbl[k].mp, tbl[k].r0, tbl[k].r1, tbl[k].p0, tbl[k].p1,
            tbl[k].fl, tbl[k].rd);
      nm = $sformatf("row%0d", k);
      chk({nm, " vld"}, 64'(o_redirect_vld), 64'(tbl[k].ev));
      chk({nm, " squash"}, 64'(o_squash), 64'(tbl[k].esq));
      chk({nm, " blk"}, 64'(o_issue_block), 64'(tbl[k].eblk));
      if (tbl[k].ev) begin
        chk({nm, " rob"}, 64'(o_redirect_robIdx), 64'(tbl[k].erob));
        chk({nm, " pc"}, o_redirect_pc, tbl[k].epc);
      end
      model_edge();
    end
`ifdef BRU_REDIRECT_PERF_EN
    apply(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    check_perf("table");
    model_edge();
`endif

    for (int n = 0; n < 2000; n++) begin
      apply(2'($urandom), 2'($urandom & $urandom), 7'($urandom), 7'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            1'(($urandom % 20) == 0), 1'(($urandom % 3) == 0));
      check_model($sformatf("rnd%0d", n));
      model_edge();
    end
`ifdef BRU_REDIRECT_PERF_EN
    apply(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    check_perf("random");
    model_edge();
`endif

    // Asynchronous reset while a redirect is pending
    apply(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    model_edge();
    apply(2'b01, 2'b01, 7'd40, 0, 64'h1234_5678, 0, 1'b0, 1'b0);
    model_edge();
    apply(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("pre-arst vld", 64'(o_redirect_vld), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst vld", 64'(o_redirect_vld), 64'd0);
    chk("arst blk", 64'(o_issue_block), 64'd0);
    chk("arst pc", o_redirect_pc, 64'd0);
    chk("arst rob", 64'(o_redirect_robIdx), 64'd0);
    model_reset();
`ifdef BRU_REDIRECT_PERF_EN
    check_perf("arst");
`endif
    @(negedge clk);
    rst = 1'b0;
    apply(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    check_model("post-arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
